traffic_light_ctrl: RTL and testbench

- Master FSM for the highway / farm-road intersection.
- Drives the start-clear input of the intersection interval timer and consumes its two timeout flags: long timeout (count 29) and short timeout (count 2).
- Sequences highway and farm-road lights based on a farm-road car sensor.
- Sits between the sensor/light pads and the timer; it is the only block that asserts the timer's start-clear.

---
 rtl/traffic_light_ctrl.sv | 129 ++++++++++++
 tb/tb_traffic_light_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Master controller for the highway / farm-road intersection.
// Sequences both sets of lights from the farm-road car sensor and the
// interval timer's long/short timeout flags, and is the sole source of
// the timer's start-clear pulse.
//
// Timer handshake: sc is a registered one-cycle pulse issued together with
// every state change; the timer clears on the following edge. While sc=1 the
// timer flags still describe the previous interval, so tl/ts are masked in
// that cycle.
module traffic_light_ctrl #(
   parameter bit         LATCH_CAR = 1'b1,
   parameter logic [1:0] LGREEN    = 2'b00,
   parameter logic [1:0] LYELLOW   = 2'b01,
   parameter logic [1:0] LRED      = 2'b10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       car,
   input  logic       tl,
   input  logic       ts,
   output logic       sc,
   output logic [1:0] hl,
   output logic [1:0] fl,
   output logic [1:0] st
);

   typedef enum logic [1:0] {
      HG = 2'b00,
      HY = 2'b01,
      FG = 2'b10,
      FY = 2'b11
   } state_t;

   state_t     state;
   state_t     next_state;
   logic       force_sc;
   logic       sc_next;
   logic       car_req;
   logic       car_req_next;
   logic       req;
   logic       tl_v;
   logic       ts_v;
   logic [1:0] hl_next;
   logic [1:0] fl_next;

   assign st = state;

   // Timer flags are stale during the clear cycle, so mask them there.
   assign tl_v = tl & ~sc;
   assign ts_v = ts & ~sc;

   // Effective farm-road request: latched pulses plus the live level.
   assign req = LATCH_CAR ? (car_req | car) : car;

   // Request latch: any car sample sets it, entering FG clears it, set wins.
   always_comb begin
      car_req_next = car_req;
      if (!LATCH_CAR) begin
         car_req_next = 1'b0;
      end else if (car) begin
         car_req_next = 1'b1;
      end else if ((next_state == FG) && (state != FG)) begin
         car_req_next = 1'b0;
      end
   end

   // State register together with the registered lights, sc and request latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= HG;
         hl      <= LGREEN;
         fl      <= LRED;
         sc      <= 1'b0;
         car_req <= 1'b0;
      end else begin
         state   <= next_state;
         hl      <= hl_next;
         fl      <= fl_next;
         sc      <= sc_next;
         car_req <= car_req_next;
      end
   end

   // Next-state decision; FG releases on the live car level, not the latch.
   always_comb begin
      next_state = state;
      force_sc   = 1'b0;
      case (state)
         HG: if (tl_v && req)  next_state = HY;
         HY: if (ts_v)         next_state = FG;
         FG: if (tl_v || !car) next_state = FY;
         FY: if (ts_v)         next_state = HG;
         default: begin
            next_state = HG;
            force_sc   = 1'b1;
         end
      endcase
   end

   // Output decode from the next state so lights and sc update with st.
   always_comb begin
      sc_next = (next_state != state) | force_sc;
      hl_next = LGREEN;
      fl_next = LRED;
      case (next_state)
         HG: begin
            hl_next = LGREEN;
            fl_next = LRED;
         end
         HY: begin
            hl_next = LYELLOW;
            fl_next = LRED;
         end
         FG: begin
            hl_next = LRED;
            fl_next = LGREEN;
         end
         FY: begin
            hl_next = LRED;
            fl_next = LYELLOW;
         end
         default: begin
            hl_next = LGREEN;
            fl_next = LRED;
         end
      endcase
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: two instances (latched and live
// sensor), each with its own interval timer model counting 0..29 saturating.
module tb_traffic_light_ctrl;

   localparam logic [1:0] G = 2'b00;
   localparam logic [1:0] Y = 2'b01;
   localparam logic [1:0] R = 2'b10;

   logic       clk;
   logic       rst;
   logic       car;

   logic       d_sc, n_sc;
   logic [1:0] d_hl, d_fl, d_st;
   logic [1:0] n_hl, n_fl, n_st;
   logic       d_tl, d_ts, n_tl, n_ts;
   logic [4:0] d_cnt, n_cnt;

   logic       force_en;
   logic       force_tl;
   logic       force_ts;

   int tests_run;
   int tests_failed;
   int sc_seen;
   int excl_viol;

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   traffic_light_ctrl #(.LATCH_CAR(1'b1)) d_dut (
      .clk(clk), .rst(rst), .car(car), .tl(d_tl), .ts(d_ts),
      .sc(d_sc), .hl(d_hl), .fl(d_fl), .st(d_st)
   );

   traffic_light_ctrl #(.LATCH_CAR(1'b0)) n_dut (
      .clk(clk), .rst(rst), .car(car), .tl(n_tl), .ts(n_ts),
      .sc(n_sc), .hl(n_hl), .fl(n_fl), .st(n_st)
   );

   // interval timer models: clear on sc, saturate at 29
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              d_cnt <= 5'd0;
      else if (d_sc)        d_cnt <= 5'd0;
      else if (d_cnt < 5'd29) d_cnt <= d_cnt + 5'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              n_cnt <= 5'd0;
      else if (n_sc)        n_cnt <= 5'd0;
      else if (n_cnt < 5'd29) n_cnt <= n_cnt + 5'd1;
   end

   assign d_tl = force_en ? force_tl : (d_cnt == 5'd29);
   assign d_ts = force_en ? force_ts : (d_cnt == 5'd2);
   assign n_tl = (n_cnt == 5'd29);
   assign n_ts = (n_cnt == 5'd2);

   // both lights non-red at once is never allowed
   always @(negedge clk) begin
      if (!rst && (d_hl != R) && (d_fl != R)) excl_viol++;
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      tests_run++;
      assert (obs === exp_v) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_lights(input string tag, input logic [1:0] st_e,
                             input logic sc_e, input logic [1:0] hl_e, input logic [1:0] fl_e);
      chk({tag, "_st"}, {6'd0, d_st}, {6'd0, st_e});
      chk({tag, "_sc"}, {7'd0, d_sc}, {7'd0, sc_e});
      chk({tag, "_hl"}, {6'd0, d_hl}, {6'd0, hl_e});
      chk({tag, "_fl"}, {6'd0, d_fl}, {6'd0, fl_e});
   endtask

   task automatic restart(input logic car_v);
      rst = 1'b1;
      car = car_v;
      tick(1);
      rst = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      excl_viol    = 0;
      rst      = 1'b1;
      car      = 1'b0;
      force_en = 1'b0;
      force_tl = 1'b0;
      force_ts = 1'b0;
      tick(3);

      // reset state
      chk_lights("rst", 2'b00, 1'b0, G, R);
      chk("rst_req", {7'd0, d_dut.car_req}, 8'd0);

      // idle with car=0 for 100 cycles: HG, no sc, timer saturates
      rst = 1'b0;
      sc_seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (d_sc === 1'b1 || n_sc === 1'b1) sc_seen++;
      end
      chk("idle_sc_count", sc_seen[7:0], 8'd0);
      chk_lights("idle", 2'b00, 1'b0, G, R);
      chk("idle_tl", {7'd0, d_tl}, 8'd1);

      // saturated timer: request exits on the next edge
      car = 1'b1;
      tick(1);
      chk_lights("sat", 2'b01, 1'b1, Y, R);
      chk("sat_n_st", {6'd0, n_st}, 8'd1);
      car = 1'b0;

      // full cycle with car held from reset release (edge k after release)
      restart(1'b1);
      tick(29);
      chk("A_hg29_st", {6'd0, d_st}, 8'd0);
      tick(1);                                   // edge 30
      chk_lights("A_hy", 2'b01, 1'b1, Y, R);
      tick(1);
      chk("A_hy_sc_drop", {7'd0, d_sc}, 8'd0);
      tick(2);                                   // edge 33
      chk("A_hy_end_st", {6'd0, d_st}, 8'd1);
      tick(1);                                   // edge 34
      chk_lights("A_fg", 2'b10, 1'b1, R, G);
      tick(30);                                  // edge 64
      chk("A_fg_hold_st", {6'd0, d_st}, 8'd2);
      tick(1);                                   // edge 65
      chk_lights("A_fy", 2'b11, 1'b1, R, Y);
      tick(3);
      chk("A_fy_end_st", {6'd0, d_st}, 8'd3);
      tick(1);                                   // edge 69
      chk_lights("A_hg", 2'b00, 1'b1, G, R);
      tick(30);
      chk("A_hg_min_st", {6'd0, d_st}, 8'd0);
      tick(1);
      chk("A_hg_exit_st", {6'd0, d_st}, 8'd1);

      // single-cycle car pulse on edge 5: latched instance serves it
      restart(1'b0);
      tick(4);
      car = 1'b1;
      tick(1);
      car = 1'b0;
      chk("B_req_set", {7'd0, d_dut.car_req}, 8'd1);
      tick(24);                                  // edge 29
      chk("B_hg29_st", {6'd0, d_st}, 8'd0);
      tick(1);                                   // edge 30
      chk("B_hy_st", {6'd0, d_st}, 8'd1);
      chk("B_n_hold_st", {6'd0, n_st}, 8'd0);
      tick(4);                                   // edge 34
      chk("B_fg_st", {6'd0, d_st}, 8'd2);
      chk("B_req_clr", {7'd0, d_dut.car_req}, 8'd0);
      tick(1);
      chk_lights("B_fy", 2'b11, 1'b1, R, Y);
      chk("B_n_st", {6'd0, n_st}, 8'd0);
      chk("B_n_sc", {7'd0, n_sc}, 8'd0);

      // car drops 10 cycles into FG
      restart(1'b1);
      tick(34);
      chk("C_fg_st", {6'd0, d_st}, 8'd2);
      tick(10);
      chk("C_fg10_st", {6'd0, d_st}, 8'd2);
      car = 1'b0;
      tick(1);
      chk_lights("C_fy", 2'b11, 1'b1, R, Y);
      tick(3);
      chk("C_fy_end_st", {6'd0, d_st}, 8'd3);
      tick(1);
      chk_lights("C_hg", 2'b00, 1'b1, G, R);

      // blanking: flags forced high during the sc cycle are ignored
      car      = 1'b1;
      force_en = 1'b1;
      force_tl = 1'b1;
      force_ts = 1'b1;
      tick(1);
      chk("D_blank_hg_st", {6'd0, d_st}, 8'd0);
      chk("D_blank_hg_sc", {7'd0, d_sc}, 8'd0);
      tick(1);
      chk("D_hy_st", {6'd0, d_st}, 8'd1);
      tick(1);
      chk("D_blank_hy_st", {6'd0, d_st}, 8'd1);
      tick(1);
      chk("D_fg_st", {6'd0, d_st}, 8'd2);
      force_en = 1'b0;

      // asynchronous reset in the middle of FY
      restart(1'b1);
      tick(34);
      car = 1'b0;
      tick(1);
      chk("E_fy_st", {6'd0, d_st}, 8'd3);
      chk("E_req_pre", {7'd0, d_dut.car_req}, 8'd1);
      #2 rst = 1'b1;
      #1;
      chk_lights("E_rst", 2'b00, 1'b0, G, R);
      chk("E_rst_req", {7'd0, d_dut.car_req}, 8'd0);
      @(negedge clk);
      car = 1'b1;
      rst = 1'b0;
      tick(29);
      chk("E_hg29_st", {6'd0, d_st}, 8'd0);
      tick(1);
      chk_lights("E_hy", 2'b01, 1'b1, Y, R);

      chk("excl_lights", excl_viol[7:0], 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
